// File: rtl/toom_8_pkg.sv
// toom_8_pkg: shared definitions for the toom_8 long divider.
//   TOOM_N        : default operand width (divisor / quotient / remainder).
//   toom_8_state_e: divider sequencing states.
package toom_8_pkg;

  localparam int TOOM_N = 1024;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } toom_8_state_e;

endpackage : toom_8_pkg

// File: rtl/toom_8_divider_if.sv
// toom_8_divider_if: operand/result handshake bundle of the divider.
//   in_valid/in_ready   : operand pair handshake (dividend 2N bits, divisor N bits)
//   out_valid/out_ready : result handshake (quotient, remainder, div_by_zero, overflow)
//   modport slave       : the divider side
//   modport master      : the producer/consumer side
interface toom_8_divider_if #(
  parameter int N = toom_8_pkg::TOOM_N
) ();

  logic           in_valid;
  logic           in_ready;
  logic [2*N-1:0] dividend;
  logic [N-1:0]   divisor;
  logic           out_valid;
  logic           out_ready;
  logic [N-1:0]   quotient;
  logic [N-1:0]   remainder;
  logic           div_by_zero;
  logic           overflow;

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero, overflow
  );

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero, overflow
  );

endinterface : toom_8_divider_if

// File: rtl/toom_8_div_step.sv
// toom_8_div_step: one restoring-division iteration (purely combinational).
//   t       in  N+1 : shifted partial remainder with the next dividend bit appended
//   divisor in  N   : divisor
//   r       out N   : new partial remainder
//   q_bit   out 1   : quotient bit produced by this iteration
module toom_8_div_step
  import toom_8_pkg::*;
#(
  parameter int N = TOOM_N
) (
  input  logic [N:0]   t,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] r,
  output logic         q_bit
);

  // Compare-and-subtract. While the partial remainder stays below the divisor,
  // t - divisor fits in N bits, so the low N bits of t can be subtracted alone.
  always_comb begin
    q_bit = (t >= {1'b0, divisor});
    if (q_bit) begin
      r = t[N-1:0] - divisor;
    end else begin
      r = t[N-1:0];
    end
  end

endmodule : toom_8_div_step

// File: rtl/toom_8_divider.sv
// toom_8_divider: sequential restoring divider, 2N-bit dividend by N-bit divisor,
// one quotient bit per clock, N iterations per operation.
//   clk     : sole clock, rising edge
//   reset_n : synchronous active-low reset
//   bus     : toom_8_divider_if.slave (operand and result handshakes, flags)
// Optional build macro DIV_OVERFLOW_CHK_EN: when defined, an operation whose
// dividend high half is >= divisor finishes at once with overflow=1; when not
// defined, overflow is always 0 and such operations run the full N iterations.
module toom_8_divider
  import toom_8_pkg::*;
#(
  parameter int N = TOOM_N
) (
  input  logic        clk,
  input  logic        reset_n,
  toom_8_divider_if.slave bus
);

  localparam int             CW         = $clog2(N);
  localparam logic [CW-1:0]  CNT_LAST_C = CW'(N - 1);
  localparam logic [CW-1:0]  CNT_ZERO_C = {CW{1'b0}};
  localparam logic [CW-1:0]  CNT_ONE_C  = {{(CW-1){1'b0}}, 1'b1};

  toom_8_state_e state_r;
  toom_8_state_e state_s;

  logic [N-1:0]  divisor_r;
  logic [N-1:0]  shift_r;      // dividend low half, consumed MSB first
  logic [N-1:0]  rem_r;        // partial remainder; its (N+1)th bit lives only in t_s
  logic [N-1:0]  quot_r;
  logic [CW-1:0] count_r;
  logic          dbz_r;
  logic          overflow_r;
  logic          in_ready_r;
  logic          out_valid_r;

  logic          accept_s;
  logic          dvs_zero_s;
  logic          ovf_hit_s;
  logic [N:0]    t_s;
  logic [N-1:0]  step_r_s;
  logic          step_q_s;

  assign accept_s   = (state_r == IDLE) && bus.in_valid;
  assign dvs_zero_s = (bus.divisor == {N{1'b0}});

`ifdef DIV_OVERFLOW_CHK_EN
  // Quotient cannot fit in N bits when the high half already reaches the divisor.
  assign ovf_hit_s = !dvs_zero_s && (bus.dividend[2*N-1:N] >= bus.divisor);
`else
  assign ovf_hit_s = 1'b0;
`endif

  assign t_s = {rem_r, shift_r[N-1]};

  toom_8_div_step #(.N(N)) u_step (
    .t       (t_s),
    .divisor (divisor_r),
    .r       (step_r_s),
    .q_bit   (step_q_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; divide-by-zero and overflow skip RUN entirely.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.in_valid) begin
          if (dvs_zero_s || ovf_hit_s) begin
            state_s = DONE;
          end else begin
            state_s = RUN;
          end
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (count_r == CNT_ZERO_C) begin
          state_s = DONE;
        end else begin
          state_s = RUN;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Handshake outputs registered from the next state so they track state_r exactly.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      in_ready_r  <= (state_s == IDLE);
      out_valid_r <= (state_s == DONE);
    end
  end

  // Datapath: operand capture, iteration, and result hold.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      divisor_r  <= {N{1'b0}};
      shift_r    <= {N{1'b0}};
      rem_r      <= {N{1'b0}};
      quot_r     <= {N{1'b0}};
      count_r    <= CNT_ZERO_C;
      dbz_r      <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            divisor_r  <= bus.divisor;
            shift_r    <= bus.dividend[N-1:0];
            count_r    <= CNT_LAST_C;
            dbz_r      <= 1'b0;
            overflow_r <= 1'b0;
            if (dvs_zero_s) begin
              quot_r <= {N{1'b1}};
              rem_r  <= bus.dividend[N-1:0];
              dbz_r  <= 1'b1;
            end else if (ovf_hit_s) begin
              quot_r     <= {N{1'b1}};
              rem_r      <= {N{1'b0}};
              overflow_r <= 1'b1;
            end else begin
              quot_r <= {N{1'b0}};
              rem_r  <= bus.dividend[2*N-1:N];
            end
          end
        end
        RUN: begin
          rem_r   <= step_r_s;
          quot_r  <= {quot_r[N-2:0], step_q_s};
          shift_r <= {shift_r[N-2:0], 1'b0};
          if (count_r != CNT_ZERO_C) begin
            count_r <= count_r - CNT_ONE_C;
          end
        end
        DONE: begin
          // results held until the output handshake
        end
        default: begin
          // unreachable encoding; the FSM returns to IDLE
        end
      endcase
    end
  end

  assign bus.in_ready    = in_ready_r;
  assign bus.out_valid   = out_valid_r;
  assign bus.quotient    = quot_r;
  assign bus.remainder   = rem_r;
  assign bus.div_by_zero = dbz_r;
  assign bus.overflow    = overflow_r;

endmodule : toom_8_divider

// File: tb/tb_toom_8_divider.sv
// tb_toom_8_divider: directed self-checking bench for toom_8_divider with a
// result scoreboard (expected results queued at operand acceptance).
module tb_toom_8_divider;

  localparam int N     = 1024;
  localparam int LIMIT = N + 16;

  typedef struct {
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         dbz;
    logic         ovf;
    int           lat;
  } exp_t;

  logic clk;
  logic reset_n;
  int   n_assert;
  int   n_fail;
  exp_t sb[$];

  toom_8_divider_if #(.N(N)) bus ();

  toom_8_divider #(.N(N)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s observed(low192)=%0h expected(low192)=%0h", tag, obs[191:0], exp[191:0]);
      $error("check %s", tag);
    end
  endtask

  function automatic exp_t model(input logic [2*N-1:0] dvd, input logic [N-1:0] dvs);
    exp_t e;
    logic [2*N-1:0] wide_dvs;
    logic [2*N-1:0] qq;
    logic [2*N-1:0] rr;
    if (dvs == '0) begin
      e.q = '1; e.r = dvd[N-1:0]; e.dbz = 1'b1; e.ovf = 1'b0; e.lat = 1;
    end else begin
      wide_dvs = {{N{1'b0}}, dvs};
      qq = dvd / wide_dvs;
      rr = dvd % wide_dvs;
      e.q = qq[N-1:0]; e.r = rr[N-1:0]; e.dbz = 1'b0; e.ovf = 1'b0; e.lat = N + 1;
    end
    return e;
  endfunction

  task automatic drive(input logic [2*N-1:0] dvd, input logic [N-1:0] dvs);
    bus.dividend = dvd;
    bus.divisor  = dvs;
    bus.in_valid = 1'b1;
  endtask

  task automatic wait_accept(input exp_t e, input bit drop, output int waited);
    waited = 0;
    @(negedge clk);
    while (!bus.in_ready && waited < LIMIT) begin
      @(negedge clk);
      waited++;
    end
    check("accept_in_time", N'(waited < LIMIT), N'(1));
    @(posedge clk);
    #1;
    sb.push_back(e);
    if (drop) bus.in_valid = 1'b0;
    check("busy_after_accept", N'(bus.in_ready), N'(0));
  endtask

  task automatic wait_result();
    int   k;
    exp_t e;
    k = 0;
    while (!bus.out_valid && k < LIMIT) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("result_in_time", N'(k < LIMIT), N'(1));
    check("sb_entry", N'(sb.size()), N'(1));
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check("quotient", bus.quotient, e.q);
      check("remainder", bus.remainder, e.r);
      check("div_by_zero", N'(bus.div_by_zero), N'(e.dbz));
      check("overflow", N'(bus.overflow), N'(e.ovf));
      check("latency", N'(k + 1), N'(e.lat));
    end
  endtask

  task automatic handshake();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check("out_valid_cleared", N'(bus.out_valid), N'(0));
    check("in_ready_idle", N'(bus.in_ready), N'(1));
  endtask

  task automatic run_op(input logic [2*N-1:0] dvd, input logic [N-1:0] dvs, input exp_t e);
    int w;
    drive(dvd, dvs);
    wait_accept(e, 1'b1, w);
    wait_result();
    handshake();
  endtask

  initial begin
    logic [2*N-1:0] dvd;
    logic [2*N-1:0] ones_w;
    logic [N-1:0]   dvs;
    exp_t           e;
    exp_t           ea;
    int             w;

    n_assert = 0;
    n_fail   = 0;
    reset_n  = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", N'(bus.in_ready), N'(1));
    check("rst_out_valid", N'(bus.out_valid), N'(0));
    check("rst_quotient", bus.quotient, '0);
    check("rst_remainder", bus.remainder, '0);
    check("rst_dbz", N'(bus.div_by_zero), N'(0));
    check("rst_ovf", N'(bus.overflow), N'(0));
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // 100 / 7
    e.q = N'(14); e.r = N'(2); e.dbz = 1'b0; e.ovf = 1'b0; e.lat = N + 1;
    run_op(2048'(100), N'(7), e);

    // (2^N-1)^2 / (2^N-1)
    ones_w = {{N{1'b0}}, {N{1'b1}}};
    dvd = ones_w * ones_w;
    dvs = '1;
    e.q = '1; e.r = '0; e.dbz = 1'b0; e.ovf = 1'b0; e.lat = N + 1;
    run_op(dvd, dvs, e);
    check("model_big", model(dvd, dvs).q, e.q);

    // 5 / 0
    run_op(2048'(5), N'(0), model(2048'(5), N'(0)));

    // 2^N / 1: high half reaches the divisor
    dvd = '0;
    dvd[N] = 1'b1;
`ifdef DIV_OVERFLOW_CHK_EN
    e.q = '1; e.r = '0; e.dbz = 1'b0; e.ovf = 1'b1; e.lat = 1;
`else
    // restoring iterations keep r=1 and emit a 1 every step
    e.q = '1; e.r = N'(1); e.dbz = 1'b0; e.ovf = 1'b0; e.lat = N + 1;
`endif
    run_op(dvd, N'(1), e);

    // random operands with high half below a large divisor
    for (int i = 0; i < N / 32; i++) dvs[i*32 +: 32] = $urandom();
    dvs[N-1] = 1'b1;
    for (int i = 0; i < 2 * N / 32; i++) dvd[i*32 +: 32] = $urandom();
    dvd[2*N-1] = 1'b0;
    run_op(dvd, dvs, model(dvd, dvs));

    // reset in the middle of an operation
    drive(2048'(100), N'(7));
    wait_accept(model(2048'(100), N'(7)), 1'b1, w);
    repeat (500) @(posedge clk);
    #1;
    reset_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check("midrst_out_valid", N'(bus.out_valid), N'(0));
      check("midrst_in_ready", N'(bus.in_ready), N'(1));
      check("midrst_quotient", bus.quotient, '0);
      check("midrst_remainder", bus.remainder, '0);
    end
    reset_n = 1'b1;
    sb.delete();
    e.q = N'(3); e.r = N'(0); e.dbz = 1'b0; e.ovf = 1'b0; e.lat = N + 1;
    run_op(2048'(9), N'(3), e);

    // back-pressure in DONE with in_valid held high
    ea = model(2048'(100), N'(7));
    drive(2048'(100), N'(7));
    wait_accept(ea, 1'b0, w);
    bus.dividend = 2048'(9);
    bus.divisor  = N'(3);
    wait_result();
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      check("bp_out_valid", N'(bus.out_valid), N'(1));
      check("bp_in_ready", N'(bus.in_ready), N'(0));
      check("bp_quotient", bus.quotient, ea.q);
      check("bp_remainder", bus.remainder, ea.r);
    end
    handshake();
    wait_accept(model(2048'(9), N'(3)), 1'b1, w);
    check("bp_accept_next_cycle", N'(w), N'(0));
    wait_result();
    handshake();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_toom_8_divider

// File: doc/toom_8_divider.md
TOOM_8_DIVIDER -- requirements
Module: toom_8_divider

Interface
REQ-001 SHALL have parameter N, default 1024, divisor/quotient/remainder width; dividend width is 2N.
REQ-002 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have port reset_n  in  1  synchronous, active-low reset.
REQ-004 SHALL have port in_valid  in  1  operand pair valid.
REQ-005 SHALL have port in_ready  out  1  block accepts operands.
REQ-006 SHALL have port dividend  in  2N  unsigned dividend, e.g. a multiplier product.
REQ-007 SHALL have port divisor  in  N  unsigned divisor.
REQ-008 SHALL have port out_valid  out  1  result valid.
REQ-009 SHALL have port out_ready  in  1  consumer accepts result.
REQ-010 SHALL have port quotient  out  N  unsigned quotient.
REQ-011 SHALL have port remainder  out  N  unsigned remainder.
REQ-012 SHALL have port div_by_zero  out  1  result flag, divisor was zero.
REQ-013 SHALL have port overflow  out  1  result flag, quotient exceeds N bits.

Function
REQ-014 SHALL implement FSM IDLE, RUN, DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-015 SHALL accept on an edge with in_valid&&in_ready: latch divisor, dividend low half into shift register, remainder register (N+1 bits) loaded with dividend high half, bit counter = N-1.
REQ-016 On acceptance with divisor==0: SHALL go directly to DONE with quotient all-ones, remainder = dividend[N-1:0], div_by_zero=1, overflow=0.
REQ-017 In RUN, each cycle SHALL form t={r[N-1:0], next dividend MSB}; if t>=divisor then r=t-divisor and quotient bit=1, else r=t and bit=0; quotient shifts in LSB-first position from MSB down.
REQ-018 After the iteration with counter==0, SHALL enter DONE; for a normal operation accepted at edge T, out_valid SHALL be high after edge T+N (latency N+1 edges, 1025 at default).
REQ-019 In DONE, quotient, remainder and flags SHALL hold stable until out_valid&&out_ready; on that edge return to IDLE with out_valid=0.
REQ-020 SHALL not overlap operations; in_valid during RUN/DONE is ignored and unaccepted.
REQ-021 Results SHALL satisfy dividend = quotient*divisor + remainder, remainder < divisor, whenever div_by_zero=0 and overflow=0.
REQ-022 in_valid and out_ready asserted together in DONE SHALL only complete the output handshake; new operands are accepted no earlier than the next cycle.

Reset
REQ-023 reset_n=0 on an edge SHALL force IDLE, in_ready=1 after reset, out_valid=0, quotient=0, remainder=0, div_by_zero=0, overflow=0, counter=0, from any state including mid-RUN; the in-flight operation is discarded.

Configuration
REQ-024 With DIV_OVERFLOW_CHK_EN defined: on acceptance with divisor!=0 and dividend[2N-1:N]>=divisor, SHALL go directly to DONE with quotient all-ones, remainder=0, overflow=1.
REQ-025 Without DIV_OVERFLOW_CHK_EN: overflow SHALL be tied 0, no check is made, every nonzero-divisor operation runs N cycles, and results for dividend[2N-1:N]>=divisor are deterministic but not arithmetically meaningful.

Structure
REQ-026 Shared package toom_8_pkg SHALL hold localparam TOOM_N=1024 and the FSM state enum (IDLE, RUN, DONE).
REQ-027 One combinational sub-module toom_8_div_step SHALL implement a single compare/subtract iteration (inputs N+1-bit t, N-bit divisor; outputs N-bit r, quotient bit).

Verification
REQ-028 dividend=100, divisor=7 -> quotient=14, remainder=2, out_valid after N+1 edges, flags 0.
REQ-029 dividend=(2^1024-1)^2, divisor=2^1024-1 -> quotient=2^1024-1, remainder=0.
REQ-030 divisor=0, dividend=5 -> out_valid one edge after accept, quotient all-ones, remainder=5, div_by_zero=1.
REQ-031 With macro: dividend=2^1024, divisor=1 -> overflow=1, quotient all-ones, remainder=0, one-edge latency; without macro: overflow=0, N+1 latency.
REQ-032 reset_n low at iteration 500, then new op 9/3 -> out_valid 0 through reset, fresh result quotient=3, remainder=0.
REQ-033 out_ready held low 20 cycles in DONE, in_valid high throughout -> outputs stable, in_ready=0, second op accepted only after output handshake.
